// File: rtl/entropy_sampler_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : entropy_sampler_ctrl_if
// Brief    : Valid/ready stream carrying assembled 32-bit random words.
// Revision : 1.0 - initial release
// ============================================================================
interface entropy_sampler_ctrl_if;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;

    modport master (
        output rnd_data,
        output rnd_valid,
        input  rnd_ready
    );

    modport slave (
        input  rnd_data,
        input  rnd_valid,
        output rnd_ready
    );
endinterface
`default_nettype wire

// File: rtl/entropy_sampler_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : entropy_sampler_ctrl
// Brief    : Sequences the ring-oscillator entropy source, decimates its bit
//            stream into 32-bit words and runs a repetition-count health test.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_sampler_ctrl #(
    parameter int WARMUP_CYCLES = 256,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_en_i,
    input  logic [31:0]            cfg_deltax_i,
    input  logic [31:0]            cfg_deltay_i,
    input  logic                   ent_bit_i,
    output logic                   ent_rst_o,
    output logic                   ent_enb_o,
    output logic [31:0]            osc_deltax_o,
    output logic [31:0]            osc_deltay_o,
    output logic                   busy_o,
    output logic                   health_fail_o,
    input  logic                   fail_clr_i,
    entropy_sampler_ctrl_if.master rnd_if
);

    localparam int C_WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int C_DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [C_WARM_W-1:0] C_WARM_LAST = C_WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]          C_REP_LIMIT = 8'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_WARMUP  = 3'd2,
        S_COLLECT = 3'd3,
        S_HOLD    = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rst_cnt_q, rst_cnt_d;
    logic [C_WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [C_DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [30:0]         shift_q, shift_d;
    logic [7:0]          rep_cnt_q, rep_cnt_d;
    logic                prev_q, prev_d;
    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic [31:0]         dx_q, dx_d;
    logic [31:0]         dy_q, dy_d;
    logic                ent_rst_q, ent_enb_q, busy_q, fail_q;

    logic        w_sample;
    logic [7:0]  w_rep_next;
    logic [31:0] w_shift_next;
    logic        w_gen_off;

    assign w_sample     = (state_q == S_COLLECT) && (div_cnt_q == C_DIV_LAST);
    assign w_rep_next   = (ent_bit_i == prev_q) ? (rep_cnt_q + 8'd1) : 8'd1;
    assign w_shift_next = {shift_q, ent_bit_i};

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        warm_cnt_d = warm_cnt_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rep_cnt_d  = rep_cnt_q;
        prev_d     = prev_q;
        data_d     = data_q;
        valid_d    = valid_q;
        dx_d       = dx_q;
        dy_d       = dy_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_en_i) begin
                    state_d    = S_RST;
                    dx_d       = cfg_deltax_i;
                    dy_d       = cfg_deltay_i;
                    rst_cnt_d  = 1'b0;
                    warm_cnt_d = '0;
                    rep_cnt_d  = 8'd0;
                    prev_d     = 1'b0;
                end
            end
            S_RST: begin
                if (!ctrl_en_i) begin
                    state_d = S_IDLE;
                end else if (rst_cnt_q) begin
                    state_d    = S_WARMUP;
                    warm_cnt_d = '0;
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            S_WARMUP: begin
                if (!ctrl_en_i) begin
                    state_d = S_IDLE;
                end else if (warm_cnt_q == C_WARM_LAST) begin
                    state_d = S_COLLECT;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (w_sample) begin
                    rep_cnt_d = w_rep_next;
                    prev_d    = ent_bit_i;
                    shift_d   = w_shift_next[30:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
                // Health failure outranks a ctrl_en drop, which outranks word completion.
                if (w_sample && (w_rep_next == C_REP_LIMIT)) begin
                    state_d = S_FAIL;
                    valid_d = 1'b0;
                end else if (!ctrl_en_i) begin
                    state_d = S_IDLE;
                end else if (w_sample && (bit_cnt_q == 5'd31)) begin
                    state_d = S_HOLD;
                    data_d  = w_shift_next;
                    valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (valid_q && rnd_if.rnd_ready) begin
                    valid_d   = 1'b0;
                    bit_cnt_d = 5'd0;
                    div_cnt_d = '0;
                    state_d   = ctrl_en_i ? S_COLLECT : S_IDLE;
                end
            end
            S_FAIL: begin
                if (fail_clr_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any exit to IDLE or FAIL throws away the partially assembled word.
        if ((state_d == S_IDLE) || (state_d == S_FAIL)) begin
            shift_d   = '0;
            bit_cnt_d = 5'd0;
            div_cnt_d = '0;
        end
    end

    assign w_gen_off = (state_d == S_IDLE) || (state_d == S_RST) || (state_d == S_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= 1'b0;
            warm_cnt_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= 5'd0;
            shift_q    <= '0;
            rep_cnt_q  <= 8'd0;
            prev_q     <= 1'b0;
            data_q     <= 32'd0;
            valid_q    <= 1'b0;
            dx_q       <= 32'd0;
            dy_q       <= 32'd0;
            ent_rst_q  <= 1'b1;
            ent_enb_q  <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rep_cnt_q  <= rep_cnt_d;
            prev_q     <= prev_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            ent_rst_q  <= w_gen_off;
            ent_enb_q  <= ~w_gen_off;
            busy_q     <= (state_d != S_IDLE) && (state_d != S_FAIL);
            fail_q     <= (state_d == S_FAIL);
        end
    end

    assign ent_rst_o        = ent_rst_q;
    assign ent_enb_o        = ent_enb_q;
    assign osc_deltax_o     = dx_q;
    assign osc_deltay_o     = dy_q;
    assign busy_o           = busy_q;
    assign health_fail_o    = fail_q;
    assign rnd_if.rnd_data  = data_q;
    assign rnd_if.rnd_valid = valid_q;

endmodule
`default_nettype wire
